// File: rtl/pipeline_control.sv
// Control and hazard unit for the 3-stage RISC-V datapath.
// Decodes the D-stage word, tracks X/M destinations, stalls on load-use, squashes after redirects.
module pipeline_control #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] inst_doutb,
    input  logic        branch_taken,
    output logic [2:0]  PC_sel,
    output logic [1:0]  data_forward_ALU1,
    output logic [2:0]  data_forward_ALU2,
    output logic [3:0]  ALUop,
    output logic [1:0]  wbsrc,
    output logic        RegWr,
    output logic [3:0]  dmem_we,
    output logic        stall
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {RST_PC, RUN, STALL, FLUSH} state_t;

    typedef struct packed {
        logic       regwr;
        logic [4:0] rd;
        logic       is_load;
        logic [1:0] wbsrc;
        logic [1:0] size;
    } stage_t;

    localparam stage_t BUBBLE = '{regwr: 1'b0, rd: 5'd0, is_load: 1'b0,
                                  wbsrc: 2'd1, size: 2'd0};

    state_t state_q, state_d;
    stage_t x_q, x_d, m_q, dec_s;

    logic        known;
    logic [31:0] inst;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        b30;

    always_comb begin
        unique case (inst_doutb[6:0])
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known = 1'b1;
            default:                           known = 1'b0;
        endcase
    end

    // Wrong-path, reset-time and unknown words all decode as the bubble.
    assign inst = (state_q == FLUSH || state_q == RST_PC || !known)
                ? NOP_INST : inst_doutb;
    assign op  = inst[6:0];
    assign rd  = inst[11:7];
    assign f3  = inst[14:12];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign b30 = inst[30];

    logic       use1, use2, wr, is_ld, is_jmp, is_br;
    logic [1:0] wb, size;
    logic [3:0] aop;
    logic [2:0] bsel;

    always_comb begin
        use1   = 1'b0;
        use2   = 1'b0;
        wr     = 1'b0;
        is_ld  = 1'b0;
        is_jmp = 1'b0;
        is_br  = 1'b0;
        wb     = 2'd1;
        size   = 2'd0;
        aop    = 4'd0;
        bsel   = 3'd0;
        unique case (op)
            OP_R: begin
                use1 = 1'b1;
                use2 = 1'b1;
                wr   = 1'b1;
                aop  = {b30, f3};
            end
            OP_I: begin
                use1 = 1'b1;
                wr   = 1'b1;
                aop  = {(f3 == 3'b101) & b30, f3};
                bsel = (f3 == 3'b001 || f3 == 3'b101) ? 3'd4 : 3'd3;
            end
            OP_LOAD: begin
                use1  = 1'b1;
                wr    = 1'b1;
                is_ld = 1'b1;
                wb    = 2'd2;
                bsel  = 3'd3;
            end
            OP_STORE: begin
                use1 = 1'b1;
                use2 = 1'b1;
                unique case (f3)
                    3'b000:  size = 2'd1;
                    3'b001:  size = 2'd2;
                    3'b010:  size = 2'd3;
                    default: size = 2'd0;
                endcase
            end
            OP_BR: begin
                use1  = 1'b1;
                use2  = 1'b1;
                is_br = 1'b1;
                aop   = {1'b0, f3};
            end
            OP_JAL: begin
                wr     = 1'b1;
                is_jmp = 1'b1;
                wb     = 2'd0;
            end
            OP_JALR: begin
                use1   = 1'b1;
                wr     = 1'b1;
                is_jmp = 1'b1;
                wb     = 2'd0;
                bsel   = 3'd3;
            end
            OP_LUI: begin
                wr   = 1'b1;
                aop  = 4'b1010;
                bsel = 3'd5;
            end
            OP_AUIPC: begin
                wr   = 1'b1;
                bsel = 3'd5;
            end
            default: ;
        endcase
    end

    assign dec_s = '{regwr: wr && (rd != 5'd0), rd: rd, is_load: is_ld,
                     wbsrc: wb, size: size};

    logic xh1, xh2, mh1, mh2, lu;
    logic [1:0] fwd_a;
    logic [2:0] fwd_b;

    assign xh1 = x_q.regwr && (x_q.rd != 5'd0) && (x_q.rd == rs1);
    assign xh2 = x_q.regwr && (x_q.rd != 5'd0) && (x_q.rd == rs2);
    assign mh1 = m_q.regwr && (m_q.rd != 5'd0) && (m_q.rd == rs1);
    assign mh2 = m_q.regwr && (m_q.rd != 5'd0) && (m_q.rd == rs2);
    assign lu  = x_q.is_load && ((use1 && xh1) || (use2 && xh2));

    assign fwd_a = !use1 ? 2'd0 : xh1 ? 2'd1 : mh1 ? 2'd2 : 2'd0;
    assign fwd_b = !use2 ? bsel : xh2 ? 3'd1 : mh2 ? 3'd2 : 3'd0;

    always_comb begin
        state_d           = state_q;
        PC_sel            = 3'd1;
        stall             = 1'b0;
        x_d               = dec_s;
        data_forward_ALU1 = fwd_a;
        data_forward_ALU2 = fwd_b;
        ALUop             = aop;
        unique case (state_q)
            RST_PC: begin
                PC_sel            = 3'd4;
                data_forward_ALU1 = 2'd0;
                data_forward_ALU2 = 3'd0;
                ALUop             = 4'd0;
                x_d               = BUBBLE;
                state_d           = RUN;
            end
            FLUSH: state_d = RUN;
            default: begin
                if (lu) begin
                    PC_sel  = 3'd0;
                    stall   = 1'b1;
                    x_d     = BUBBLE;
                    state_d = STALL;
                end else if (is_jmp) begin
                    PC_sel  = 3'd2;
                    state_d = FLUSH;
                end else if (is_br && branch_taken) begin
                    PC_sel  = 3'd3;
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_comb begin
        unique case (x_q.size)
            2'd1:    dmem_we = 4'b0001;
            2'd2:    dmem_we = 4'b0011;
            2'd3:    dmem_we = 4'b1111;
            default: dmem_we = 4'b0000;
        endcase
    end

    assign wbsrc = m_q.wbsrc;
    assign RegWr = m_q.regwr;

    logic unused_bits;
    assign unused_bits = ^{inst[31], inst[29:25], m_q.rd, m_q.is_load, m_q.size};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= RST_PC;
            x_q     <= BUBBLE;
            m_q     <= BUBBLE;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            m_q     <= x_q;
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized scoreboard bench for pipeline_control.
// An instruction-level model predicts each cycle; a negedge monitor compares.
module tb_pipeline_control;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] inst_doutb = NOP;
    logic        branch_taken = 1'b0;
    logic [2:0]  PC_sel;
    logic [1:0]  data_forward_ALU1;
    logic [2:0]  data_forward_ALU2;
    logic [3:0]  ALUop;
    logic [1:0]  wbsrc;
    logic        RegWr;
    logic [3:0]  dmem_we;
    logic        stall;

    pipeline_control #(.NOP_INST(NOP)) dut (
        .Clock(Clock), .Reset(Reset), .inst_doutb(inst_doutb),
        .branch_taken(branch_taken), .PC_sel(PC_sel),
        .data_forward_ALU1(data_forward_ALU1),
        .data_forward_ALU2(data_forward_ALU2), .ALUop(ALUop),
        .wbsrc(wbsrc), .RegWr(RegWr), .dmem_we(dmem_we), .stall(stall)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0] pc;
        logic [1:0] f1;
        logic [2:0] f2;
        logic [3:0] aop;
        logic [1:0] wb;
        logic       rw;
        logic [3:0] we;
        logic       st;
    } exp_t;

    typedef struct {
        int         dst;
        bit         ld;
        int         wb;
        logic [3:0] be;
        bit         u1, u2;
        int         rs1, rs2;
        logic [3:0] aop;
        int         bimm;
        bit         jmp, br;
    } info_t;

    exp_t sbq[$];
    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mx = NOP;
    logic [31:0] mm = NOP;
    bit m_boot = 1'b1;
    bit m_squash = 1'b0;
    bit last_stall = 1'b0;

    function automatic info_t dec(input logic [31:0] win);
        info_t r;
        logic [31:0] w;
        logic [2:0] f3;
        bit wr;
        w = win;
        if (!(w[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                             7'b0010111}))
            w = NOP;
        f3 = w[14:12];
        r = '{dst: 0, ld: 0, wb: 1, be: 4'b0, u1: 0, u2: 0,
              rs1: int'(w[19:15]), rs2: int'(w[24:20]), aop: 4'b0,
              bimm: 0, jmp: 0, br: 0};
        wr = 0;
        case (w[6:0])
            7'b0110011: begin r.u1 = 1; r.u2 = 1; wr = 1; r.aop = {w[30], f3}; end
            7'b0010011: begin
                r.u1 = 1; wr = 1;
                r.aop = {(f3 == 3'd5) ? w[30] : 1'b0, f3};
                r.bimm = (f3 == 3'd1 || f3 == 3'd5) ? 4 : 3;
            end
            7'b0000011: begin r.u1 = 1; wr = 1; r.ld = 1; r.wb = 2; r.bimm = 3; end
            7'b0100011: begin
                r.u1 = 1; r.u2 = 1;
                r.be = (f3 == 0) ? 4'b0001 : (f3 == 1) ? 4'b0011 :
                       (f3 == 2) ? 4'b1111 : 4'b0000;
            end
            7'b1100011: begin r.u1 = 1; r.u2 = 1; r.br = 1; r.aop = {1'b0, f3}; end
            7'b1101111: begin wr = 1; r.jmp = 1; r.wb = 0; end
            7'b1100111: begin r.u1 = 1; wr = 1; r.jmp = 1; r.wb = 0; r.bimm = 3; end
            7'b0110111: begin wr = 1; r.aop = 4'b1010; r.bimm = 5; end
            default:    begin wr = 1; r.bimm = 5; end
        endcase
        if (wr) r.dst = int'(w[11:7]);
        return r;
    endfunction

    task automatic cycle(input bit rst, input logic [31:0] w, input bit bt);
        exp_t e;
        info_t d, xi, mi;
        logic [31:0] wv;
        bit boot, lu;
        Reset = rst;
        inst_doutb = w;
        branch_taken = bt;
        if (!rst) begin
            mx = NOP;
            mm = NOP;
            m_squash = 0;
        end
        boot = !rst || m_boot;
        wv = m_squash ? NOP : w;
        d  = dec(wv);
        xi = dec(mx);
        mi = dec(mm);
        lu = !boot && xi.ld && xi.dst != 0 &&
             ((d.u1 && d.rs1 == xi.dst) || (d.u2 && d.rs2 == xi.dst));
        e.we = xi.be;
        e.rw = (mi.dst != 0);
        e.wb = 2'(mi.wb);
        if (boot) begin
            e.pc = 4; e.f1 = 0; e.f2 = 0; e.aop = 0; e.st = 0;
        end else begin
            e.st  = lu;
            e.aop = d.aop;
            e.pc  = lu ? 3'd0 : d.jmp ? 3'd2 : (d.br && bt) ? 3'd3 : 3'd1;
            if (!d.u1) e.f1 = 0;
            else if (xi.dst != 0 && xi.dst == d.rs1) e.f1 = 1;
            else if (mi.dst != 0 && mi.dst == d.rs1) e.f1 = 2;
            else e.f1 = 0;
            if (!d.u2) e.f2 = 3'(d.bimm);
            else if (xi.dst != 0 && xi.dst == d.rs2) e.f2 = 1;
            else if (mi.dst != 0 && mi.dst == d.rs2) e.f2 = 2;
            else e.f2 = 0;
        end
        sbq.push_back(e);
        mm = mx;
        mx = (boot || lu) ? NOP : wv;
        m_squash = !boot && !lu && (d.jmp || (d.br && bt));
        last_stall = lu;
        m_boot = !rst;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_chk++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, ex);
        end
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("PC_sel", 32'(PC_sel), 32'(e.pc));
            chk("fwd_ALU1", 32'(data_forward_ALU1), 32'(e.f1));
            chk("fwd_ALU2", 32'(data_forward_ALU2), 32'(e.f2));
            chk("ALUop", 32'(ALUop), 32'(e.aop));
            chk("wbsrc", 32'(wbsrc), 32'(e.wb));
            chk("RegWr", 32'(RegWr), 32'(e.rw));
            chk("dmem_we", 32'(dmem_we), 32'(e.we));
            chk("stall", 32'(stall), 32'(e.st));
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int rs2, rs1, input logic [2:0] f3);
        return {7'd0, 5'(rs2), 5'(rs1), f3, 5'd0, 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int rs2, rs1, input logic [2:0] f3);
        return {7'd0, 5'(rs2), 5'(rs1), f3, 5'b01000, 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int rd, input int imm);
        logic [20:0] j;
        j = 21'(imm);
        return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] rand_inst();
        int k, rd, a, b;
        logic [2:0] f3;
        logic [6:0] f7;
        k  = $urandom_range(0, 10);
        rd = $urandom_range(0, 3);
        a  = $urandom_range(0, 3);
        b  = $urandom_range(0, 3);
        f3 = 3'($urandom_range(0, 7));
        f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        case (k)
            0, 10: return enc_r(f7, b, a, f3, rd);
            1: return enc_i(int'($urandom_range(0, 4095)), a, f3, rd, 7'b0010011);
            2: return enc_i(4, a, 3'd2, rd, 7'b0000011);
            3: return enc_s(b, a, 3'($urandom_range(0, 3)));
            4: return enc_b(b, a, f3);
            5: return enc_j(rd, 8);
            6: return enc_i(0, a, 3'd0, rd, 7'b1100111);
            7: return {20'($urandom), 5'(rd), 7'b0110111};
            8: return {20'($urandom), 5'(rd), 7'b0010111};
            default: return {25'($urandom), 7'b1111111};
        endcase
    endfunction

    task automatic issue(input logic [31:0] w, input bit bt);
        cycle(1, w, bt);
        if (last_stall) cycle(1, w, bt);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(NOP, 0);
    endtask

    initial begin
        logic [31:0] w;
        @(posedge Clock);
        #1;
        for (int i = 0; i < 3; i++) cycle(0, NOP, 0);
        cycle(1, NOP, 0);
        nops(3);

        issue(enc_r(7'h00, 3, 2, 3'd0, 1), 0);
        issue(enc_r(7'h20, 5, 1, 3'd0, 4), 0);
        nops(3);

        issue(enc_i(0, 7, 3'd2, 6, 7'b0000011), 0);
        issue(enc_r(7'h00, 6, 6, 3'd0, 8), 0);
        nops(3);

        issue(enc_b(2, 1, 3'd0), 1);
        issue(enc_i(5, 0, 3'd0, 9, 7'b0010011), 0);
        issue(enc_i(1, 0, 3'd0, 10, 7'b0010011), 0);
        nops(3);

        issue(enc_j(1, 16), 0);
        issue(enc_s(5, 2, 3'd2), 0);
        nops(3);

        issue(enc_i(7, 0, 3'd0, 0, 7'b0010011), 0);
        issue(enc_r(7'h00, 0, 0, 3'd0, 1), 0);
        nops(3);

        issue(enc_i(0, 7, 3'd2, 6, 7'b0000011), 0);
        issue(enc_b(0, 6, 3'd0), 1);
        issue(enc_i(5, 0, 3'd0, 9, 7'b0010011), 0);
        nops(3);

        issue(enc_i(0, 7, 3'd2, 6, 7'b0000011), 0);
        cycle(1, enc_r(7'h00, 6, 6, 3'd0, 8), 0);
        cycle(0, enc_r(7'h00, 6, 6, 3'd0, 8), 0);
        cycle(1, NOP, 0);
        nops(3);

        issue(enc_j(1, 16), 0);
        cycle(0, enc_s(5, 2, 3'd2), 0);
        cycle(1, NOP, 0);
        nops(3);

        w = rand_inst();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) != 0, w, $urandom_range(0, 1));
            if (!last_stall) w = rand_inst();
        end

        @(negedge Clock);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Control and hazard unit for the 3-stage RISC-V datapath (Decode/Fetch, Execute, Memory/Writeback). It decodes the instruction currently presented by instruction memory and drives the datapath's PC select, forwarding muxes, ALU op, writeback source and register-file write enable. It tracks destination registers through the X and M stages, inserts a one-cycle stall on load-use hazards, and squashes the wrong-path instruction after taken branches and jumps. It sits beside the datapath as its sole sequencer.

## Interface

Parameters:
- NOP_INST, 32'h0000_0013, the bubble instruction (addi x0,x0,0) injected into X on stall or flush.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- inst_doutb  in  32  instruction word from instruction memory, valid in the D stage.
- branch_taken  in  1  branch comparison result from the datapath for the D-stage instruction.
- PC_sel  out  3  0 hold, 1 PC+4, 2 jump target, 3 branch target, 4 zero.
- data_forward_ALU1  out  2  ALU A source: 0 rd1, 1 X result, 2 M result.
- data_forward_ALU2  out  3  ALU B source: 0 rd2, 1 X, 2 M, 3 I-imm, 4 shamt, 5 U-imm.
- ALUop  out  4  {funct7[5] for R-type/SRAI, else 0; funct3}; ADD (4'b0000) for load/store/JAL/JALR/AUIPC; 4'b1010 (copy B) for LUI.
- wbsrc  out  2  writeback source of the M-stage instruction: 0 PC+4, 1 ALU, 2 dmem, 3 UART.
- RegWr  out  1  register-file write enable for the M-stage instruction.
- dmem_we  out  4  byte write enables for the store in X (SB/SH/SW by addr[1:0] = 0; datapath shifts).
- stall  out  1  high while the D-stage instruction is held.

## Operation

- FSM states: RST_PC, RUN, STALL, FLUSH.
- RST_PC: entered asynchronously while Reset is low, and held for the first edge after release. PC_sel=4. X and M hold bubbles. The next state is RUN.
- RUN: the instruction is decoded normally. The next state is chosen in priority order:
  - Load-use: X holds a load with rd_x ≠ 0, and rd_x equals the D instruction's rs1 (or rs2, for R/S/B types). Result: PC_sel=0, stall=1, a bubble goes to X, and the next state is STALL.
  - JAL/JALR: PC_sel=2, and the next state is FLUSH.
  - Branch with branch_taken=1: PC_sel=3, and the next state is FLUSH.
  - Otherwise: PC_sel=1, and the state stays RUN.
- STALL: exactly one cycle. The held instruction is re-decoded, and forwarding now selects M (2). The next state is decided by the same rules as RUN, so a branch or jump proceeds from here.
- FLUSH: inst_doutb is the wrong-path word. It is treated as NOP_INST, so no RegWr and no store. PC_sel=1, and the next state is RUN.
- Pipeline tracking: X and M registers each hold {regwr, rd, is_load, wbsrc, store size}. They advance every cycle. A bubble clears regwr and the store size.
- Forwarding, per source operand:
  - X match (regwr_x && rd_x ≠ 0 && rd_x == rs) selects 1.
  - Otherwise an M match selects 2.
  - Otherwise 0 for A, and the immediate select for I/U/shift types on B.
  - When both X and M match, X takes priority.
- x0 is never forwarded and never written: regwr is forced to 0 when rd = 0.
- Unknown opcodes are decoded as NOP.

## Timing

- Decode outputs (PC_sel, data_forward_*, ALUop, stall, dmem_we) are combinational from inst_doutb and the registered state/X regs. There are no paths from branch_taken to state except through the PC_sel decode.
- wbsrc and RegWr come directly from the M-stage registers, i.e. 2 cycles after decode.
- Load-use penalty: 1 cycle. Taken branch/jump penalty: 1 squashed cycle.
- Values while Reset is low: PC_sel=4, RegWr=0, data_forward_ALU1=0, data_forward_ALU2=0, ALUop=0, wbsrc=1, dmem_we=0, stall=0. All pipeline registers hold bubbles.
- Reset asserted mid-stall or mid-flush: the unit returns immediately to RST_PC. No pending write survives.
- Load-use and branch in the same decode: the stall wins, and the branch resolves in STALL with forwarded operands.

## Test plan

- Reset: hold Reset low for 3 cycles, then release. PC_sel=4 while low and for 1 cycle after, then 1. RegWr stays 0 for 2 more cycles.
- ADD x1,x2,x3 followed by SUB x4,x1,x5: on SUB decode, data_forward_ALU1=1 and ALUop=4'b1000. Two cycles later, RegWr=1 and wbsrc=1.
- LW x6,0(x7) followed by ADD x8,x6,x6: stall=1 and PC_sel=0 for one cycle, then data_forward_ALU1=2, data_forward_ALU2=2, and no double execution.
- BEQ with branch_taken=1: PC_sel=3. The next fetched word (ADDI x9,x0,5) produces no RegWr. The following cycle shows PC_sel=1.
- JAL x1,+16 then SW in the shadow: PC_sel=2, dmem_we stays 4'b0000 for the squashed SW, and RegWr=1 with wbsrc=0 for JAL.
- ADDI x0,x0,7 followed by ADD x1,x0,x0: no forwarding (data_forward_ALU1=0) and RegWr=0 for the ADDI.
